// File: rtl/plaintext_validator_if.sv
// Byte stream from the keystream XOR stage plus the A-RAM write port that
// the plaintext validator drives.
interface plaintext_validator_if #(
  parameter int RAM_WIDTH          = 8,
  parameter int MESSAGE_LOG_LENGTH = 5
);
  logic                          in_valid;
  logic                          in_ready;
  logic [RAM_WIDTH-1:0]          in_data;
  logic [MESSAGE_LOG_LENGTH-1:0] aAddr;
  logic [RAM_WIDTH-1:0]          aIn;
  logic                          aWren;

  // Upstream producer / RAM observer side.
  modport master (
    output in_valid, in_data,
    input  in_ready, aAddr, aIn, aWren
  );

  // Validator side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, aAddr, aIn, aWren
  );
endinterface

// File: rtl/plaintext_validator.sv
// Plaintext validator: stores each decrypted byte into the core's A-RAM and
// checks it against the allowed alphabet, reporting pass/fail per candidate key.
//
// state  | meaning
// IDLE   | waiting for start, nothing accepted
// ACCEPT | taking bytes, all accepted bytes legal so far
// PASS   | full message accepted and legal
// FAIL   | an illegal byte was seen; fail_index holds its position
module plaintext_validator #(
  parameter int                   MESSAGE_LENGTH     = 32,
  parameter int                   MESSAGE_LOG_LENGTH = 5,
  parameter int                   RAM_WIDTH          = 8,
  parameter logic [RAM_WIDTH-1:0] CHAR_LO            = 8'h61,
  parameter logic [RAM_WIDTH-1:0] CHAR_HI            = 8'h7a,
  parameter bit                   ALLOW_SPACE        = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  plaintext_validator_if.slave          bus,
  output logic                          done,
  output logic                          pass,
  output logic [MESSAGE_LOG_LENGTH-1:0] fail_index,
  output logic [MESSAGE_LOG_LENGTH:0]   byte_count
);

  typedef enum logic [1:0] {IDLE, ACCEPT, PASS, FAIL} state_t;

  localparam logic [RAM_WIDTH-1:0]        SPACE_CHAR = RAM_WIDTH'(8'h20);
  localparam logic [MESSAGE_LOG_LENGTH:0] LAST_IDX   = (MESSAGE_LOG_LENGTH+1)'(MESSAGE_LENGTH-1);
  localparam logic [MESSAGE_LOG_LENGTH:0] COUNT_ONE  = {{MESSAGE_LOG_LENGTH{1'b0}}, 1'b1};

  state_t state, state_nxt;
  logic   accept;
  logic   legal;
  logic   last_byte;

  // start blocks acceptance so a restart never swallows a byte of the old stream.
  assign bus.in_ready = (state == ACCEPT) && !start;
  assign accept       = bus.in_valid && bus.in_ready;
  assign legal        = ((bus.in_data >= CHAR_LO) && (bus.in_data <= CHAR_HI)) ||
                        (ALLOW_SPACE && (bus.in_data == SPACE_CHAR));
  assign last_byte    = (byte_count == LAST_IDX);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and status outputs; start overrides every state.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      ACCEPT: begin
        if (accept) begin
          if (!legal)         state_nxt = FAIL;
          else if (last_byte) state_nxt = PASS;
        end
      end
      PASS: begin
        done = 1'b1;
        pass = 1'b1;
      end
      FAIL: begin
        done = 1'b1;
      end
      default: ;
    endcase
    if (start) state_nxt = ACCEPT;
  end

  // A-RAM write port, byte counter and first-failure index.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.aAddr  <= '0;
      bus.aIn    <= '0;
      bus.aWren  <= 1'b0;
      byte_count <= '0;
      fail_index <= '0;
    end else begin
      bus.aWren <= accept;
      if (accept) begin
        bus.aAddr <= byte_count[MESSAGE_LOG_LENGTH-1:0];
        bus.aIn   <= bus.in_data;
      end
      if (start) begin
        byte_count <= '0;
        fail_index <= '0;
      end else if (accept) begin
        byte_count <= byte_count + COUNT_ONE;
        if (!legal) fail_index <= byte_count[MESSAGE_LOG_LENGTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_plaintext_validator.sv
// Scoreboard bench for plaintext_validator: a reference model predicts each
// A-RAM write and the status outputs; a monitor checks every aWren pulse.
module tb_plaintext_validator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       done, pass, done_ns, pass_ns;
  logic [4:0] fail_index, fail_index_ns;
  logic [5:0] byte_count, byte_count_ns;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;

  logic [12:0] exp_q [$];
  logic [7:0]  msg [32];

  typedef enum int {M_IDLE, M_ACC, M_PASS, M_FAIL} mstate_t;
  mstate_t    m_state = M_IDLE;
  int         m_count = 0;
  logic [4:0] m_fail = '0;
  bit         armed = 1'b0;
  bit         acc_seen = 1'b0;

  plaintext_validator_if #(.RAM_WIDTH(8), .MESSAGE_LOG_LENGTH(5)) ifc ();
  plaintext_validator_if #(.RAM_WIDTH(8), .MESSAGE_LOG_LENGTH(5)) ifc_ns ();

  assign ifc_ns.in_valid = ifc.in_valid;
  assign ifc_ns.in_data  = ifc.in_data;

  plaintext_validator #(.ALLOW_SPACE(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .bus(ifc),
    .done(done), .pass(pass), .fail_index(fail_index), .byte_count(byte_count)
  );

  plaintext_validator #(.ALLOW_SPACE(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .start(start), .bus(ifc_ns),
    .done(done_ns), .pass(pass_ns), .fail_index(fail_index_ns), .byte_count(byte_count_ns)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [7:0] d);
    return (d >= 8'h61 && d <= 8'h7a) || (d == 8'h20);
  endfunction

  // Reference model: compare current outputs, then advance to the post-edge state.
  always @(negedge clk) begin
    bit exp_ready;
    if (armed) begin
      chk("done", {31'b0, done}, {31'b0, (m_state == M_PASS || m_state == M_FAIL)});
      chk("pass", {31'b0, pass}, {31'b0, (m_state == M_PASS)});
      chk("byte_count", {26'b0, byte_count}, m_count);
      if (m_state == M_FAIL) chk("fail_index", {27'b0, fail_index}, {27'b0, m_fail});
    end
    exp_ready = (m_state == M_ACC) && !start;
    if (armed) chk("in_ready", {31'b0, ifc.in_ready}, {31'b0, exp_ready});
    acc_seen = 1'b0;
    if (reset) begin
      m_state = M_IDLE; m_count = 0; m_fail = '0; armed = 1'b1;
    end else if (start) begin
      m_state = M_ACC; m_count = 0; m_fail = '0;
    end else if (exp_ready && ifc.in_valid) begin
      acc_seen = 1'b1;
      exp_q.push_back({m_count[4:0], ifc.in_data});
      if (!is_legal(ifc.in_data)) begin
        m_state = M_FAIL; m_fail = m_count[4:0];
      end else if (m_count == 31) begin
        m_state = M_PASS;
      end
      m_count++;
    end
  end

  // Write monitor: every aWren pulse must match the oldest predicted write.
  always @(negedge clk) begin
    logic [12:0] e;
    if (ifc.aWren === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write: got aAddr=%0d aIn=0x%0h with none expected", ifc.aAddr, ifc.aIn);
      end else begin
        e = exp_q.pop_front();
        chk("wr_aAddr", {27'b0, ifc.aAddr}, {27'b0, e[12:8]});
        chk("wr_aIn", {24'b0, ifc.aIn}, {24'b0, e[7:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_msg(input int n, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 400) begin
      ifc.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      ifc.in_data  = msg[i];
      tick();
      if (acc_seen) i++;
      guard++;
    end
    ifc.in_valid = 1'b0;
    if (i < n) begin
      checks++; failures++;
      $display("FAIL send_timeout: accepted %0d bytes, required %0d", i, n);
    end
  endtask

  task automatic fill_legal();
    for (int i = 0; i < 32; i++) msg[i] = 8'h61 + 8'(i % 26);
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    // reset values
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_pass", {31'b0, pass}, 0);
    chk("rst_byte_count", {26'b0, byte_count}, 0);
    chk("rst_fail_index", {27'b0, fail_index}, 0);
    chk("rst_aWren", {31'b0, ifc.aWren}, 0);
    chk("rst_aAddr", {27'b0, ifc.aAddr}, 0);
    chk("rst_aIn", {24'b0, ifc.aIn}, 0);
    chk("rst_in_ready", {31'b0, ifc.in_ready}, 0);
    reset = 1'b0;
    tick();

    // pass path, back-to-back
    fill_legal();
    do_start();
    wr_count = 0;
    send_msg(32, 1'b0);
    chk("pass_done", {31'b0, done}, 1);
    chk("pass_pass", {31'b0, pass}, 1);
    chk("pass_last_wren", {31'b0, ifc.aWren}, 1);
    chk("pass_last_addr", {27'b0, ifc.aAddr}, 31);
    chk("pass_byte_count", {26'b0, byte_count}, 32);
    tick(); tick();
    chk("pass_wr_count", wr_count, 32);
    chk("pass_hold", {31'b0, done & pass}, 1);

    // fail on first illegal byte
    for (int i = 0; i < 5; i++) msg[i] = 8'h61;
    msg[5] = 8'h41;
    do_start();
    wr_count = 0;
    send_msg(6, 1'b0);
    tick();
    chk("fail_done", {31'b0, done}, 1);
    chk("fail_pass", {31'b0, pass}, 0);
    chk("fail_index5", {27'b0, fail_index}, 5);
    chk("fail_wr_count", wr_count, 6);
    chk("fail_in_ready", {31'b0, ifc.in_ready}, 0);

    // space legal here, illegal in the no-space instance
    fill_legal();
    msg[3] = 8'h20;
    do_start();
    send_msg(32, 1'b0);
    tick();
    chk("space_pass", {31'b0, pass}, 1);
    chk("nospace_done", {31'b0, done_ns}, 1);
    chk("nospace_pass", {31'b0, pass_ns}, 0);
    chk("nospace_fail_index", {27'b0, fail_index_ns}, 3);

    // boundary characters just outside the range
    msg[0] = 8'h60;
    do_start();
    send_msg(1, 1'b0);
    tick();
    chk("bound_60_index", {27'b0, fail_index}, 0);
    chk("bound_60_pass", {31'b0, done & !pass}, 1);
    msg[0] = 8'h7a; msg[1] = 8'h61; msg[2] = 8'h7b;
    do_start();
    send_msg(3, 1'b0);
    tick();
    chk("bound_7b_index", {27'b0, fail_index}, 2);

    // gaps in in_valid
    fill_legal();
    do_start();
    wr_count = 0;
    send_msg(32, 1'b1);
    tick(); tick();
    chk("gaps_pass", {31'b0, pass}, 1);
    chk("gaps_wr_count", wr_count, 32);

    // restart mid-message
    do_start();
    send_msg(10, 1'b0);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 8'h71;
    start = 1'b1;
    #1;
    chk("restart_ready_low", {31'b0, ifc.in_ready}, 0);
    tick();
    start = 1'b0;
    ifc.in_valid = 1'b0;
    chk("restart_count0", {26'b0, byte_count}, 0);
    chk("restart_no_wren", {31'b0, ifc.aWren}, 0);
    send_msg(32, 1'b0);
    tick();
    chk("restart_pass", {31'b0, pass}, 1);

    // reset mid-operation
    do_start();
    send_msg(7, 1'b0);
    reset = 1'b1;
    tick();
    chk("midrst_aWren", {31'b0, ifc.aWren}, 0);
    chk("midrst_count", {26'b0, byte_count}, 0);
    chk("midrst_aAddr", {27'b0, ifc.aAddr}, 0);
    chk("midrst_ready", {31'b0, ifc.in_ready}, 0);
    reset = 1'b0;
    tick();

    // illegal last byte
    fill_legal();
    msg[31] = 8'h7b;
    do_start();
    send_msg(32, 1'b0);
    tick();
    chk("last_ill_done", {31'b0, done}, 1);
    chk("last_ill_pass", {31'b0, pass}, 0);
    chk("last_ill_index", {27'b0, fail_index}, 31);

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/plaintext_validator.md
Name: plaintext_validator

Overview:
- Per-core stage directly downstream of the RC4 keystream XOR inside each arcfour core.
- Consumes decrypted bytes over a valid/ready handshake and writes each byte into that core's message RAM (A).
- Checks every byte against the allowed plaintext alphabet: lowercase a–z, plus space when ALLOW_SPACE=1.
- Reports pass/fail per candidate key; the core feeds this into its succeeded/terminated outputs.

Parameters:
MESSAGE_LENGTH, 32, number of plaintext bytes per candidate key.
MESSAGE_LOG_LENGTH, 5, A-RAM address width; MESSAGE_LENGTH <= 2**MESSAGE_LOG_LENGTH.
RAM_WIDTH, 8, byte width.
CHAR_LO, 8'h61, lowest legal character ('a').
CHAR_HI, 8'h7a, highest legal character ('z').
ALLOW_SPACE, 1, 1 = byte 8'h20 is also legal.

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high; returns block to IDLE.
start  in  1  one-cycle pulse: begin validating a new message (new candidate key).
in_valid  in  1  in_data holds a decrypted byte.
in_ready  out  1  combinational: (state==ACCEPT) && !start.
in_data  in  RAM_WIDTH  decrypted byte.
aAddr  out  MESSAGE_LOG_LENGTH  A-RAM write address (registered).
aIn  out  RAM_WIDTH  A-RAM write data (registered).
aWren  out  1  A-RAM write enable, one-cycle pulse (registered).
done  out  1  level: validation finished (PASS or FAIL state).
pass  out  1  level: all MESSAGE_LENGTH bytes legal.
fail_index  out  MESSAGE_LOG_LENGTH  index of first illegal byte; valid when done && !pass.
byte_count  out  MESSAGE_LOG_LENGTH+1  bytes accepted since last start.

Behaviour:
- States: IDLE, ACCEPT, PASS, FAIL.
- Reset values: state=IDLE; aAddr=0, aIn=0, aWren=0, done=0, pass=0, fail_index=0, byte_count=0.
- Handshake: a byte is accepted on a cycle where in_valid && in_ready. in_data must be held by the producer until accepted. Throughput is 1 byte/cycle.
- Byte legality: legal = (CHAR_LO <= in_data <= CHAR_HI) || (ALLOW_SPACE && in_data==8'h20). Comparisons are unsigned.
- Accept action, registered: next cycle aWren=1, aAddr=byte_count[MESSAGE_LOG_LENGTH-1:0] (pre-increment value), aIn=in_data; byte_count increments. Illegal bytes are also written. aWren is 0 on every cycle without an accept.
- IDLE: in_ready=0. start -> ACCEPT.
- ACCEPT, on accept:
  - byte illegal -> FAIL; fail_index = pre-increment byte_count.
  - else if pre-increment byte_count == MESSAGE_LENGTH-1 -> PASS.
  - else stay in ACCEPT.
  - An illegal last byte goes to FAIL, not PASS.
- PASS: done=1, pass=1. FAIL: done=1, pass=0. Both hold until start or reset; in_ready=0.
- start in any state (including mid-ACCEPT):
  - next cycle state=ACCEPT; byte_count=0, done=0, pass=0, fail_index=0.
  - in_ready is forced low during the start cycle, so no byte is accepted in that cycle.
  - Any pending aWren from the previous cycle still completes.
- reset has priority over start and over any accept; reset mid-ACCEPT discards progress and issues no aWren.
- Latency: from the accept of the last byte to done=1 is 1 cycle. The final aWren occurs in the same cycle as done rising.
- byte_count never exceeds MESSAGE_LENGTH; no wrap-around because ACCEPT exits at MESSAGE_LENGTH.

Test Plan:
- Pass path: reset, start, stream 32 bytes of 8'h61..8'h7a with in_valid held high -> 32 aWren pulses on consecutive cycles with aAddr 0..31; done=pass=1 one cycle after the last accept; byte_count=32.
- Fail on first illegal byte: bytes 0–4 = 8'h61, byte 5 = 8'h41 -> FAIL; done=1, pass=0, fail_index=5; aWren count=6; in_ready=0 afterwards.
- Space handling: byte 3 = 8'h20 with ALLOW_SPACE=1 -> pass=1. Same stream with ALLOW_SPACE=0 -> fail_index=3. Boundary bytes 8'h60 and 8'h7b -> fail; 8'h61 and 8'h7a -> legal.
- Backpressure/gaps: in_valid toggled randomly over 32 legal bytes -> aAddr strictly sequential 0..31, no duplicate or skipped writes, pass=1.
- Restart mid-message: after 10 accepts, pulse start with in_valid=1 -> no accept in the start cycle; byte_count=0 next cycle; the new 32-byte legal stream passes with aAddr restarting at 0.
- Reset mid-operation and illegal last byte: reset after 7 accepts -> all outputs at reset values, state IDLE. Separately, byte 31 = 8'h7b -> FAIL, fail_index=31, pass=0.
